// File: rtl/microcode_sequencer.sv
// Microcoded control unit: 32-entry control store addressed by the
// micro-PC, external dispatch for multiway branches, instruction
// completion pulse/counter and a sticky illegal-address flag.
module microcode_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  next_address,
  output logic [4:0]  branch_target,
  output logic [4:0]  upc,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        NextPC,
  output logic        RegW,
  output logic        MemW,
  output logic        Branch,
  output logic        ALUOp,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic        instr_done,
  output logic [15:0] instr_count,
  output logic        illegal
);

  typedef enum logic [4:0] {
    S_FETCH     = 5'd0,
    S_DECODE    = 5'd1,
    S_MEMADR    = 5'd2,
    S_MEMREAD   = 5'd3,
    S_MEMWB     = 5'd4,
    S_MEMWRITE  = 5'd5,
    S_EXECUTER  = 5'd6,
    S_EXECUTEI  = 5'd7,
    S_ALUWB     = 5'd8,
    S_BRANCH    = 5'd9
  } ustate_t;

  localparam logic [4:0] LAST_LEGAL = 5'd9;

  ustate_t     upc_q;
  logic        done_q;
  logic        illegal_q;
  logic [15:0] count_q;

  logic        addr_ok;
  logic        to_fetch;

  assign addr_ok  = (next_address <= LAST_LEGAL);
  // An advance that leaves a nonzero micro-address and lands on Fetch,
  // either by a normal return or by an illegal-address redirect.
  assign to_fetch = (upc_q != S_FETCH) && (!addr_ok || (next_address == 5'd0));

  assign upc         = upc_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;
  // The completion register holds through a stall but is masked while stalled.
  assign instr_done  = done_q & en;

  // Control store: decode the current micro-address into the control word.
  always_comb begin
    IRWrite       = 1'b0;
    AdrSrc        = 1'b0;
    NextPC        = 1'b0;
    RegW          = 1'b0;
    MemW          = 1'b0;
    Branch        = 1'b0;
    ALUOp         = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ResultSrc     = 2'b00;
    branch_target = 5'd0;
    case (upc_q)
      S_FETCH: begin
        IRWrite       = 1'b1;
        ALUSrcA       = 2'b01;
        ALUSrcB       = 2'b10;
        ResultSrc     = 2'b10;
        NextPC        = 1'b1;
        branch_target = 5'd1;
      end
      S_DECODE: begin
        ALUSrcA       = 2'b01;
        ALUSrcB       = 2'b10;
        ResultSrc     = 2'b10;
        branch_target = 5'd10;
      end
      S_MEMADR: begin
        ALUSrcB       = 2'b01;
        branch_target = 5'd11;
      end
      S_MEMREAD: begin
        AdrSrc        = 1'b1;
        branch_target = 5'd4;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        RegW          = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        MemW          = 1'b1;
      end
      S_EXECUTER: begin
        ALUOp         = 1'b1;
        branch_target = 5'd8;
      end
      S_EXECUTEI: begin
        ALUSrcB       = 2'b01;
        ALUOp         = 1'b1;
        branch_target = 5'd8;
      end
      S_ALUWB: begin
        RegW          = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 2'b10;
        ALUSrcB       = 2'b01;
        ResultSrc     = 2'b10;
        Branch        = 1'b1;
      end
      default: begin
        branch_target = 5'd0;
      end
    endcase
  end

  // Sequencer state: micro-PC advance, illegal redirect, completion tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upc_q     <= S_FETCH;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else if (en) begin
      upc_q  <= addr_ok ? ustate_t'(next_address) : S_FETCH;
      done_q <= to_fetch;
      if (!addr_ok)
        illegal_q <= 1'b1;
      if (to_fetch && (count_q != '1))
        count_q <= count_q + 16'd1;
    end
  end

endmodule
